// File: rtl/cu_microsequencer_if.sv
// Sequencer bus: run control, datapath qualifiers, control-memory port and
// microword/status outputs toward the control buffer register.
interface cu_microsequencer_if #(
    parameter int unsigned CAR_WIDTH   = 8,
    parameter int unsigned OPC_WIDTH   = 6,
    parameter int unsigned UWORD_WIDTH = 24
);
    logic                   start;
    logic                   stall;
    logic                   cond;
    logic [OPC_WIDTH-1:0]   opcode;
    logic [CAR_WIDTH-1:0]   rom_addr;
    logic [UWORD_WIDTH-1:0] rom_data;
    logic [UWORD_WIDTH-1:0] microword;
    logic                   uword_valid;
    logic                   busy;
    logic                   halted;
    logic [CAR_WIDTH-1:0]   car;

    // Environment side: drives control inputs and returns ROM data.
    modport master (
        output start, stall, cond, opcode, rom_data,
        input  rom_addr, microword, uword_valid, busy, halted, car
    );

    // Sequencer side.
    modport slave (
        input  start, stall, cond, opcode, rom_data,
        output rom_addr, microword, uword_valid, busy, halted, car
    );
endinterface

// File: rtl/cu_microsequencer.sv
// Microprogram sequencer: owns the CAR, fetches microwords from a synchronous
// control ROM (1-cycle latency) and presents them for decode, two cycles per
// microword. A microword with the halt bit set stops the sequencer until reset.
module cu_microsequencer #(
    parameter int unsigned CAR_WIDTH   = 8,
    parameter int unsigned OPC_WIDTH   = 6,
    parameter int unsigned UWORD_WIDTH = 24,
    parameter int unsigned FETCH_ADDR  = 0
) (
    input logic                clk,
    input logic                rst,
    cu_microsequencer_if.slave bus
);

    localparam int unsigned HaltBit   = 23;
    localparam int unsigned NextHi    = 21;
    localparam int unsigned NextLo    = 20;

    localparam logic [CAR_WIDTH-1:0] CarOne   = CAR_WIDTH'(1);
    localparam logic [CAR_WIDTH-1:0] CarTwo   = CAR_WIDTH'(2);
    localparam logic [CAR_WIDTH-1:0] CarFetch = CAR_WIDTH'(FETCH_ADDR);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExec,
        StHalted
    } state_e;

    state_e                 state_q, state_d;
    logic [CAR_WIDTH-1:0]   car_q, car_d, car_next;
    logic [UWORD_WIDTH-1:0] microword_q, microword_d;
    logic                   advance;
    logic                   halt_word;

    // Leaving EXEC this cycle; the only moment cond/opcode matter.
    assign advance   = (state_q == StExec) && !bus.stall;
    assign halt_word = microword_q[HaltBit];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // CAR and microword registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            car_q       <= CarFetch;
            microword_q <= '0;
        end else begin
            car_q       <= car_d;
            microword_q <= microword_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.start) state_d = StLoad;
            StLoad:   state_d = StExec;
            StExec:   if (!bus.stall) state_d = halt_word ? StHalted : StLoad;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    // Next microaddress from the microword's sequencing field.
    always_comb begin
        car_next = car_q + CarOne;
        unique case (microword_q[NextHi:NextLo])
            2'b00: car_next = car_q + CarOne;
            2'b01: car_next = CAR_WIDTH'({bus.opcode, 2'b00});
            2'b10: car_next = CarFetch;
            2'b11: car_next = car_q + (bus.cond ? CarTwo : CarOne);
            default: car_next = car_q + CarOne;
        endcase
    end

    // Datapath next values: latch ROM data in LOAD, advance CAR on release.
    always_comb begin
        car_d       = car_q;
        microword_d = microword_q;
        if (state_q == StLoad) begin
            microword_d = bus.rom_data;
        end
        if (advance && !halt_word) begin
            car_d = car_next;
        end
    end

    // Outputs; rom_addr looks ahead so the next LOAD finds its data ready.
    always_comb begin
        bus.uword_valid = (state_q == StExec);
        bus.busy        = (state_q == StLoad) || (state_q == StExec);
        bus.halted      = (state_q == StHalted);
        bus.rom_addr    = advance ? car_next : car_q;
        bus.microword   = microword_q;
        bus.car         = car_q;
    end

endmodule

// File: tb/tb_cu_microsequencer.sv
// Bench for cu_microsequencer: ROM array with 1-cycle read latency, directed
// scenarios followed by randomized microprograms checked per microword.
module tb_cu_microsequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cu_microsequencer_if bus_if ();

    cu_microsequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic [23:0] rom [256];

    // Synchronous control memory.
    always @(posedge clk) bus_if.rom_data <= rom[bus_if.rom_addr];

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_car;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Next microaddress as the microword's sequencing field defines it.
    function automatic int unsigned model_next(input int unsigned pc, input logic [23:0] w,
                                               input logic c, input int unsigned op);
        case (w[21:20])
            2'd0:    return (pc + 1) % 256;
            2'd1:    return op * 4;
            2'd2:    return 0;
            default: return (pc + (c ? 2 : 1)) % 256;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(bus_if.uword_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check_eq({tag, "_halted"}, 32'(bus_if.halted), 32'd0);
        check_eq({tag, "_uword"}, 32'(bus_if.microword), 32'd0);
        check_eq({tag, "_car"}, 32'(bus_if.car), 32'd0);
        check_eq({tag, "_rom_addr"}, 32'(bus_if.rom_addr), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_car = 0;
    endtask

    // Pulse start from IDLE; returns in the first EXEC cycle.
    task automatic do_start();
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check_eq("first_load_valid", 32'(bus_if.uword_valid), 32'd0);
        check_eq("first_load_busy", 32'(bus_if.busy), 32'd1);
        @(negedge clk);
    endtask

    // Entered in an EXEC cycle; stalls nstall cycles, releases with c/op.
    // Returns in the next EXEC cycle, or in HALTED with did_halt set.
    task automatic exec_uword(input int nstall, input logic c, input logic [5:0] op,
                              output bit did_halt);
        logic [23:0] w;
        int unsigned nxt;
        w = rom[m_car];
        did_halt = 1'b0;
        check_eq("exec_valid", 32'(bus_if.uword_valid), 32'd1);
        check_eq("exec_busy", 32'(bus_if.busy), 32'd1);
        check_eq("exec_halted", 32'(bus_if.halted), 32'd0);
        check_eq("exec_uword", 32'(bus_if.microword), 32'(w));
        check_eq("exec_car", 32'(bus_if.car), m_car);
        for (int i = 0; i < nstall; i++) begin
            bus_if.stall  = 1'b1;
            bus_if.cond   = 1'($urandom_range(0, 1));
            bus_if.opcode = 6'($urandom_range(0, 63));
            bus_if.start  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("stall_valid", 32'(bus_if.uword_valid), 32'd1);
            check_eq("stall_uword", 32'(bus_if.microword), 32'(w));
            check_eq("stall_car", 32'(bus_if.car), m_car);
            check_eq("stall_rom_addr", 32'(bus_if.rom_addr), m_car);
            check_eq("stall_halted", 32'(bus_if.halted), 32'd0);
        end
        bus_if.stall  = 1'b0;
        bus_if.cond   = c;
        bus_if.opcode = op;
        bus_if.start  = 1'($urandom_range(0, 1));
        nxt = model_next(m_car, w, c, int'(op));
        #1;
        if (!w[23]) check_eq("release_rom_addr", 32'(bus_if.rom_addr), nxt);
        @(negedge clk);
        bus_if.start = 1'b0;
        if (w[23]) begin
            check_eq("halt_halted", 32'(bus_if.halted), 32'd1);
            check_eq("halt_busy", 32'(bus_if.busy), 32'd0);
            check_eq("halt_valid", 32'(bus_if.uword_valid), 32'd0);
            check_eq("halt_car", 32'(bus_if.car), m_car);
            check_eq("halt_uword", 32'(bus_if.microword), 32'(w));
            did_halt = 1'b1;
            return;
        end
        m_car = nxt;
        check_eq("load_valid", 32'(bus_if.uword_valid), 32'd0);
        check_eq("load_busy", 32'(bus_if.busy), 32'd1);
        check_eq("load_car", 32'(bus_if.car), m_car);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [23:0] t1 [4];
        logic [31:0] r;
        t1 = '{24'h000001, 24'h000002, 24'h000004, 24'h000000};
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.stall = 1'b0;
        bus_if.cond = 1'b0;
        bus_if.opcode = '0;
        m_car = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        @(negedge clk);
        check_idle("idle_hold");

        // Straight-line sequence, no stalls.
        for (int i = 0; i < 4; i++) rom[i] = t1[i];
        do_start();
        for (int k = 0; k < 4; k++) begin
            check_eq("seq_uword", 32'(bus_if.microword), 32'(t1[k]));
            check_eq("seq_car", 32'(bus_if.car), 32'(k));
            exec_uword(0, 1'b0, 6'h00, h);
        end

        // Opcode dispatch.
        do_reset();
        rom[0] = 24'h100000;
        rom[8'h14] = 24'h0ABCDE;
        do_start();
        exec_uword(0, 1'b0, 6'h05, h);
        check_eq("dispatch_car", 32'(bus_if.car), 32'h14);
        check_eq("dispatch_uword", 32'(bus_if.microword), 32'h0ABCDE);

        // Conditional skip, taken and not taken.
        do_reset();
        rom[0] = 24'h100000;
        rom[8'h20] = 24'h300000;
        do_start();
        exec_uword(0, 1'b0, 6'h08, h);
        exec_uword(0, 1'b1, 6'h00, h);
        check_eq("skip_taken_car", 32'(bus_if.car), 32'h22);
        do_reset();
        do_start();
        exec_uword(0, 1'b0, 6'h08, h);
        exec_uword(0, 1'b0, 6'h00, h);
        check_eq("skip_not_taken_car", 32'(bus_if.car), 32'h21);

        // CAR wrap from 0xFF.
        do_reset();
        for (int i = 8'hFC; i <= 8'hFF; i++) rom[i] = '0;
        do_start();
        exec_uword(0, 1'b0, 6'h3F, h);
        for (int i = 0; i < 4; i++) exec_uword(0, 1'b0, 6'h00, h);
        check_eq("wrap_car", 32'(bus_if.car), 32'h00);

        // Stall in the middle of a sequence.
        do_reset();
        rom[0] = 24'h000011;
        rom[1] = 24'h000022;
        rom[2] = 24'h000033;
        rom[3] = 24'h000044;
        do_start();
        exec_uword(0, 1'b0, 6'h00, h);
        exec_uword(3, 1'b0, 6'h00, h);
        exec_uword(0, 1'b0, 6'h00, h);
        check_eq("post_stall_uword", 32'(bus_if.microword), 32'h000044);

        // Halt entered only after stall drops; start ignored; reset exits.
        do_reset();
        rom[0] = 24'h000005;
        rom[1] = 24'h800000;
        do_start();
        exec_uword(0, 1'b0, 6'h00, h);
        exec_uword(2, 1'b0, 6'h00, h);
        check_eq("halt_seen", 32'(h), 32'd1);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        check_eq("halt_sticky", 32'(bus_if.halted), 32'd1);
        check_eq("halt_start_busy", 32'(bus_if.busy), 32'd0);
        check_eq("halt_start_car", 32'(bus_if.car), 32'd1);
        do_reset();
        check_eq("halt_rst_halted", 32'(bus_if.halted), 32'd0);
        check_eq("halt_rst_car", 32'(bus_if.car), 32'd0);

        // Reset while a microword is live.
        do_reset();
        rom[0] = 24'h000007;
        rom[1] = 24'h000009;
        do_start();
        exec_uword(0, 1'b0, 6'h00, h);
        check_eq("mid_valid_before", 32'(bus_if.uword_valid), 32'd1);
        do_reset();
        check_idle("mid_rst");
        do_start();
        check_eq("mid_restart_uword", 32'(bus_if.microword), 32'h000007);
        exec_uword(0, 1'b0, 6'h00, h);

        // Randomized microprograms.
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom();
                rom[i] = {($urandom_range(0, 19) == 0), r[22:0]};
            end
            do_reset();
            do_start();
            for (int k = 0; k < 40; k++) begin
                exec_uword(int'($urandom_range(0, 3)) - 1, 1'($urandom_range(0, 1)),
                           6'($urandom_range(0, 63)), h);
                if (h) break;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
